multicycle_control: RTL and testbench

Multicycle sequencer that replaces the single-cycle Control/PC-next logic. It drives a shared-memory MIPS datapath (IR, MDR, ALUOut registers; one memory port for instruction and data) through FETCH/DECODE/EXEC/MEM/WB steps. It supports waited memory via a MemReady handshake, a watchdog, error halt, and a retired-instruction counter.

---
 rtl/multicycle_control_if.sv | 41 ++++
 rtl/multicycle_control.sv | 241 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle MIPS sequencer.
// master: the sequencer (takes IR fields, flags, MemReady; drives all controls and status).
// slave : the datapath/memory side (the reverse directions).
interface multicycle_control_if #(
    parameter int unsigned COUNT_WIDTH = 32
);
    logic [5:0]             OP;
    logic [5:0]             Funct;
    logic                   Zero;
    logic                   MemReady;
    logic                   IorD;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   IRWrite;
    logic                   PCWrite;
    logic [1:0]             PCSource;
    logic                   ALUSrcA;
    logic [1:0]             ALUSrcB;
    logic [2:0]             ALUOp;
    logic [1:0]             RegDst;
    logic [1:0]             MemtoReg;
    logic                   RegWrite;
    logic [3:0]             State;
    logic                   InstrDone;
    logic [COUNT_WIDTH-1:0] InstrCount;
    logic [1:0]             ErrorCode;

    modport master (
        input  OP, Funct, Zero, MemReady,
        output IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource,
               ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite,
               State, InstrDone, InstrCount, ErrorCode
    );

    modport slave (
        output OP, Funct, Zero, MemReady,
        input  IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource,
               ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite,
               State, InstrDone, InstrCount, ErrorCode
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle sequencer for a shared-memory MIPS datapath.
// Ports: clk, reset (sync, active-high), bus (master modport): IR fields, Zero and
// MemReady in; datapath mux selects/enables, State, InstrDone, InstrCount, ErrorCode out.
// Controls are decoded from State; only the FETCH and BRANCH write enables look at inputs.
module multicycle_control #(
    parameter int unsigned WATCHDOG_CYCLES = 255,
    parameter int unsigned COUNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    localparam int unsigned WD_W = (WATCHDOG_CYCLES < 2) ? 1 : $clog2(WATCHDOG_CYCLES);

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_R   = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b101;

    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE = 4'd1,  MEM_ADDR = 4'd2,  MEM_RD = 4'd3,
        MEM_WB   = 4'd4,  MEM_WR = 4'd5,  EXEC_R   = 4'd6,  R_WB   = 4'd7,
        BRANCH   = 4'd8,  EXEC_I = 4'd9,  I_WB     = 4'd10, JUMP   = 4'd11,
        JAL      = 4'd12, JR     = 4'd13, HALT     = 4'd14
    } state_t;

    state_t                 state, state_next;
    logic [WD_W-1:0]        wd, wd_next;
    logic [1:0]             err, err_next;
    logic [COUNT_WIDTH-1:0] count;

    logic       iord, mem_read, mem_write, ir_write, pc_write, reg_write, done;
    logic       alu_src_a, mem_wait, wd_limit;
    logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
    logic [2:0] alu_op;

    // Watchdog fires on the last allowed wait cycle; a WATCHDOG_CYCLES of 0 disables it.
    assign wd_limit = (WATCHDOG_CYCLES != 0) && (wd == WD_W'(WATCHDOG_CYCLES - 1));

    // State, watchdog, sticky error and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            wd    <= '0;
            err   <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            wd    <= wd_next;
            err   <= err_next;
            if (done) count <= count + COUNT_WIDTH'(1);
        end
    end

    // Next state and control decode.
    always_comb begin
        state_next = state;
        err_next   = err;
        wd_next    = wd;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        done       = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = ALU_ADD;
        pc_source  = 2'd0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        mem_wait   = 1'b0;

        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = bus.MemReady;
                pc_write  = bus.MemReady;
                mem_wait  = 1'b1;
                if (bus.MemReady) state_next = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'd3;
                case (bus.OP)
                    OP_R:                           state_next = (bus.Funct == FUNCT_JR) ? JR : EXEC_R;
                    OP_LW, OP_SW:                   state_next = MEM_ADDR;
                    OP_BEQ, OP_BNE:                 state_next = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_next = EXEC_I;
                    OP_J:                           state_next = JUMP;
                    OP_JAL:                         state_next = JAL;
                    default: begin
                        state_next = HALT;
                        err_next   = ERR_ILLEGAL;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                state_next = (bus.OP == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                mem_wait = 1'b1;
                if (bus.MemReady) state_next = MEM_WB;
            end
            MEM_WB: begin
                mem_to_reg = 2'd1;
                reg_write  = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                mem_wait  = 1'b1;
                if (bus.MemReady) begin
                    done       = 1'b1;
                    state_next = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_R;
                state_next = R_WB;
            end
            R_WB: begin
                reg_dst    = 2'd1;
                reg_write  = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_source  = 2'd1;
                pc_write   = ((bus.OP == OP_BEQ) && bus.Zero) || ((bus.OP == OP_BNE) && !bus.Zero);
                done       = 1'b1;
                state_next = FETCH;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                case (bus.OP)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_LUI:  alu_op = ALU_LUI;
                    default: alu_op = ALU_ADD;
                endcase
                state_next = I_WB;
            end
            I_WB: begin
                reg_write  = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                pc_source  = 2'd2;
                pc_write   = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                pc_source  = 2'd2;
                pc_write   = 1'b1;
                reg_dst    = 2'd2;
                mem_to_reg = 2'd2;
                reg_write  = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            JR: begin
                pc_source  = 2'd3;
                pc_write   = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            HALT: begin
                state_next = HALT;
            end
            default: state_next = FETCH;
        endcase

        // Memory timeout: no ready by the limit cycle means halt; ready at the limit still wins.
        if (mem_wait && !bus.MemReady && wd_limit) begin
            state_next = HALT;
            err_next   = ERR_TIMEOUT;
        end

        if (state_next != state)             wd_next = '0;
        else if (mem_wait && !bus.MemReady)  wd_next = wd + WD_W'(1);

        // Reset abandons the current instruction without any architectural write.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            mem_read  = 1'b0;
            done      = 1'b0;
        end
    end

    assign bus.IorD       = iord;
    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.PCWrite    = pc_write;
    assign bus.PCSource   = pc_source;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUOp      = alu_op;
    assign bus.RegDst     = reg_dst;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.RegWrite   = reg_write;
    assign bus.State      = state;
    assign bus.InstrDone  = done;
    assign bus.InstrCount = count;
    assign bus.ErrorCode  = err;
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (watchdog limit 4).
// Each scenario drives a per-cycle stimulus table; the expected observation for each
// cycle is pushed to a scoreboard queue when driven and popped when sampled at negedge.
module tb_multicycle_control;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   model_cnt;
    logic [5:0] cur_op;

    multicycle_control_if #(.COUNT_WIDTH(32)) bus ();

    multicycle_control #(.WATCHDOG_CYCLES(4), .COUNT_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // en = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, InstrDone}
    localparam logic [5:0] EN_NONE  = 6'b000000;
    localparam logic [5:0] EN_FWAIT = 6'b000100;
    localparam logic [5:0] EN_FGO   = 6'b110100;
    localparam logic [5:0] EN_WB    = 6'b001001;
    localparam logic [5:0] EN_JMP   = 6'b100001;
    localparam logic [5:0] EN_JAL   = 6'b101001;
    localparam logic [5:0] EN_SWW   = 6'b000010;
    localparam logic [5:0] EN_SWGO  = 6'b000011;
    localparam logic [5:0] EN_BRNT  = 6'b000001;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic       z;
        logic [3:0] st;
        logic [5:0] en;
        logic [1:0] err;
    } stim_t;

    // mux = {IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg}
    typedef struct packed {
        logic [3:0]  st;
        logic [5:0]  en;
        logic [12:0] mux;
        logic [1:0]  err;
        logic [31:0] cnt;
    } obs_t;

    obs_t sb[$];

    function automatic stim_t mk(input logic rst, input logic mr, input logic z,
                                 input logic [3:0] st, input logic [5:0] en, input logic [1:0] err);
        stim_t s;
        s.rst = rst; s.mr = mr; s.z = z; s.st = st; s.en = en; s.err = err;
        return s;
    endfunction

    // Select/ALU fields each state must present, taken from the state table.
    function automatic logic [12:0] mux_exp(input logic [3:0] st, input logic [5:0] op);
        logic [2:0] iop;
        case (op)
            6'h0C:   iop = 3'b100;
            6'h0D:   iop = 3'b011;
            6'h0F:   iop = 3'b101;
            default: iop = 3'b000;
        endcase
        case (st)
            4'd0:  return {1'b0, 1'b0, 2'd1, 3'b000, 2'd0, 2'd0, 2'd0};
            4'd1:  return {1'b0, 1'b0, 2'd3, 3'b000, 2'd0, 2'd0, 2'd0};
            4'd2:  return {1'b0, 1'b1, 2'd2, 3'b000, 2'd0, 2'd0, 2'd0};
            4'd3:  return {1'b1, 1'b0, 2'd0, 3'b000, 2'd0, 2'd0, 2'd0};
            4'd4:  return {1'b0, 1'b0, 2'd0, 3'b000, 2'd0, 2'd0, 2'd1};
            4'd5:  return {1'b1, 1'b0, 2'd0, 3'b000, 2'd0, 2'd0, 2'd0};
            4'd6:  return {1'b0, 1'b1, 2'd0, 3'b010, 2'd0, 2'd0, 2'd0};
            4'd7:  return {1'b0, 1'b0, 2'd0, 3'b000, 2'd0, 2'd1, 2'd0};
            4'd8:  return {1'b0, 1'b1, 2'd0, 3'b001, 2'd1, 2'd0, 2'd0};
            4'd9:  return {1'b0, 1'b1, 2'd2, iop,    2'd0, 2'd0, 2'd0};
            4'd11: return {1'b0, 1'b0, 2'd0, 3'b000, 2'd2, 2'd0, 2'd0};
            4'd12: return {1'b0, 1'b0, 2'd0, 3'b000, 2'd2, 2'd2, 2'd2};
            4'd13: return {1'b0, 1'b0, 2'd0, 3'b000, 2'd3, 2'd0, 2'd0};
            default: return 13'd0;
        endcase
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st  = bus.State;
        o.en  = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.InstrDone};
        o.mux = {bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.RegDst, bus.MemtoReg};
        o.err = bus.ErrorCode;
        o.cnt = bus.InstrCount;
        return o;
    endfunction

    task automatic set_instr(input logic [5:0] op, input logic [5:0] funct);
        cur_op    = op;
        bus.OP    = op;
        bus.Funct = funct;
    endtask

    // Apply one cycle of inputs and record what the cycle must look like.
    task automatic drive(input stim_t s);
        obs_t e;
        reset        = s.rst;
        bus.MemReady = s.mr;
        bus.Zero     = s.z;
        e.st  = s.st;
        e.en  = s.en;
        e.mux = mux_exp(s.st, cur_op);
        e.err = s.err;
        e.cnt = 32'(model_cnt);
        sb.push_back(e);
        if (s.rst)       model_cnt = 0;
        else if (s.en[0]) model_cnt = model_cnt + 1;
    endtask

    task automatic test_reset();
        stim_t t[$];
        obs_t a, e;
        set_instr(6'h00, 6'h20);
        t.push_back(mk(1, 1, 0, 4'd0, EN_NONE, 2'd0));
        t.push_back(mk(1, 0, 0, 4'd0, EN_NONE, 2'd0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            a = sample(); e = sb.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL reset[%0d] got %h expected %h", i, a, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load();
        stim_t t[$];
        obs_t a, e;
        set_instr(6'h23, 6'h04);
        t.push_back(mk(0, 0, 0, 4'd0, EN_FWAIT, 2'd0));
        t.push_back(mk(0, 0, 0, 4'd0, EN_FWAIT, 2'd0));
        t.push_back(mk(0, 1, 0, 4'd0, EN_FGO,   2'd0));
        t.push_back(mk(0, 0, 0, 4'd1, EN_NONE,  2'd0));
        t.push_back(mk(0, 0, 0, 4'd2, EN_NONE,  2'd0));
        t.push_back(mk(0, 0, 0, 4'd3, EN_FWAIT, 2'd0));
        t.push_back(mk(0, 0, 0, 4'd3, EN_FWAIT, 2'd0));
        t.push_back(mk(0, 1, 0, 4'd3, EN_FWAIT, 2'd0));
        t.push_back(mk(0, 0, 0, 4'd4, EN_WB,    2'd0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            a = sample(); e = sb.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL load[%0d] got %h expected %h", i, a, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        stim_t t[$];
        obs_t a, e;
        logic [5:0] op;
        logic z, taken;
        for (int k = 0; k < 4; k++) begin
            op    = (k < 2) ? 6'h04 : 6'h05;
            z     = (k == 0 || k == 3);
            taken = (op == 6'h04) ? z : !z;
            set_instr(op, 6'h00);
            t.delete();
            t.push_back(mk(0, 1, 0, 4'd0, EN_FGO,  2'd0));
            t.push_back(mk(0, 0, 0, 4'd1, EN_NONE, 2'd0));
            t.push_back(mk(0, 0, z, 4'd8, taken ? EN_JMP : EN_BRNT, 2'd0));
            foreach (t[i]) begin
                drive(t[i]);
                @(negedge clk);
                a = sample(); e = sb.pop_front(); checks++;
                if (a !== e) begin errors++; $display("FAIL branch%0d[%0d] got %h expected %h", k, i, a, e); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_jal_jr();
        stim_t t[$];
        obs_t a, e;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_instr(6'h03, 6'h10);
            else        set_instr(6'h00, 6'h08);
            t.delete();
            t.push_back(mk(0, 1, 0, 4'd0, EN_FGO,  2'd0));
            t.push_back(mk(0, 0, 0, 4'd1, EN_NONE, 2'd0));
            t.push_back(mk(0, 0, 0, (k == 0) ? 4'd12 : 4'd13, (k == 0) ? EN_JAL : EN_JMP, 2'd0));
            foreach (t[i]) begin
                drive(t[i]);
                @(negedge clk);
                a = sample(); e = sb.pop_front(); checks++;
                if (a !== e) begin errors++; $display("FAIL jal_jr%0d[%0d] got %h expected %h", k, i, a, e); end
                @(posedge clk); #1;
            end
        end
    endtask

    // add (R), ori, lui, andi, sw with a write wait, j.
    task automatic test_alu_store_jump();
        stim_t t[$];
        obs_t a, e;
        logic [5:0] ops [6] = '{6'h00, 6'h0D, 6'h0F, 6'h0C, 6'h2B, 6'h02};
        for (int k = 0; k < 6; k++) begin
            set_instr(ops[k], 6'h20);
            t.delete();
            t.push_back(mk(0, 1, 0, 4'd0, EN_FGO,  2'd0));
            t.push_back(mk(0, 0, 0, 4'd1, EN_NONE, 2'd0));
            case (k)
                0: begin
                    t.push_back(mk(0, 0, 0, 4'd6, EN_NONE, 2'd0));
                    t.push_back(mk(0, 0, 0, 4'd7, EN_WB,   2'd0));
                end
                1, 2, 3: begin
                    t.push_back(mk(0, 0, 0, 4'd9,  EN_NONE, 2'd0));
                    t.push_back(mk(0, 0, 0, 4'd10, EN_WB,   2'd0));
                end
                4: begin
                    t.push_back(mk(0, 0, 0, 4'd2, EN_NONE, 2'd0));
                    t.push_back(mk(0, 0, 0, 4'd5, EN_SWW,  2'd0));
                    t.push_back(mk(0, 1, 0, 4'd5, EN_SWGO, 2'd0));
                end
                default: t.push_back(mk(0, 0, 0, 4'd11, EN_JMP, 2'd0));
            endcase
            foreach (t[i]) begin
                drive(t[i]);
                @(negedge clk);
                a = sample(); e = sb.pop_front(); checks++;
                if (a !== e) begin errors++; $display("FAIL alu_sj%0d[%0d] got %h expected %h", k, i, a, e); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_watchdog_limit();
        stim_t t[$];
        obs_t a, e;
        set_instr(6'h23, 6'h04);
        t.push_back(mk(0, 1, 0, 4'd0, EN_FGO,   2'd0));
        t.push_back(mk(0, 0, 0, 4'd1, EN_NONE,  2'd0));
        t.push_back(mk(0, 0, 0, 4'd2, EN_NONE,  2'd0));
        for (int k = 0; k < 4; k++) t.push_back(mk(0, (k == 3), 0, 4'd3, EN_FWAIT, 2'd0));
        t.push_back(mk(0, 0, 0, 4'd4, EN_WB,    2'd0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            a = sample(); e = sb.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL wd_limit[%0d] got %h expected %h", i, a, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_watchdog_timeout();
        stim_t t[$];
        obs_t a, e;
        set_instr(6'h23, 6'h04);
        t.push_back(mk(0, 1, 0, 4'd0, EN_FGO,  2'd0));
        t.push_back(mk(0, 0, 0, 4'd1, EN_NONE, 2'd0));
        t.push_back(mk(0, 0, 0, 4'd2, EN_NONE, 2'd0));
        for (int k = 0; k < 4; k++) t.push_back(mk(0, 0, 0, 4'd3, EN_FWAIT, 2'd0));
        t.push_back(mk(0, 1, 0, 4'd14, EN_NONE,  2'd2));
        t.push_back(mk(0, 1, 0, 4'd14, EN_NONE,  2'd2));
        t.push_back(mk(1, 1, 0, 4'd14, EN_NONE,  2'd2));
        t.push_back(mk(0, 0, 0, 4'd0,  EN_FWAIT, 2'd0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            a = sample(); e = sb.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL wd_timeout[%0d] got %h expected %h", i, a, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        stim_t t[$];
        obs_t a, e;
        set_instr(6'h3F, 6'h00);
        t.push_back(mk(0, 1, 0, 4'd0, EN_FGO,  2'd0));
        t.push_back(mk(0, 0, 0, 4'd1, EN_NONE, 2'd0));
        for (int k = 0; k < 10; k++) t.push_back(mk(0, k[0], 1, 4'd14, EN_NONE, 2'd1));
        t.push_back(mk(1, 0, 0, 4'd14, EN_NONE,  2'd1));
        t.push_back(mk(0, 0, 0, 4'd0,  EN_FWAIT, 2'd0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            a = sample(); e = sb.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL illegal[%0d] got %h expected %h", i, a, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_write();
        stim_t t[$];
        obs_t a, e;
        set_instr(6'h2B, 6'h04);
        t.push_back(mk(0, 1, 0, 4'd0, EN_FGO,   2'd0));
        t.push_back(mk(0, 0, 0, 4'd1, EN_NONE,  2'd0));
        t.push_back(mk(0, 0, 0, 4'd2, EN_NONE,  2'd0));
        t.push_back(mk(1, 1, 0, 4'd5, EN_NONE,  2'd0));
        t.push_back(mk(0, 0, 0, 4'd0, EN_FWAIT, 2'd0));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            a = sample(); e = sb.pop_front(); checks++;
            if (a !== e) begin errors++; $display("FAIL reset_mid_wr[%0d] got %h expected %h", i, a, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        clk          = 1'b0;
        reset        = 1'b1;
        checks       = 0;
        errors       = 0;
        model_cnt    = 0;
        cur_op       = 6'h00;
        bus.OP       = 6'h00;
        bus.Funct    = 6'h00;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_load();
        test_branch();
        test_jal_jr();
        test_alu_store_jump();
        test_watchdog_limit();
        test_watchdog_timeout();
        test_illegal();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
